// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Round-robin arbiter sharing the single write port of the async FIFO among
// NUM_REQ producers in the write clock domain. One producer owns the port at a
// time for a bounded burst. The burst length is latched when the grant is
// made: HALF_BURST if the FIFO reports half full at that moment, otherwise
// MAX_BURST.
//
// Ports
//   wclk          write-domain clock, rising edge
//   wrst_n        asynchronous active-low reset
//   req_valid     per-lane "word available"
//   req_data      packed lanes, lane i = [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     per-lane accept strobe (only the owner's bit can be high)
//   wfull         FIFO full flag, stalls the current burst
//   wHalf_full    FIFO half-full flag, sampled only when a grant is made
//   write_enable  FIFO write strobe
//   data_write    FIFO write data (lane of grant_id)
//   grant_id      current / most recent owner
//   busy          high while a burst is in progress
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 9,
  parameter  int MAX_BURST  = 8,
  parameter  int HALF_BURST = 2,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          wclk,
  input  logic                          wrst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          wfull,
  input  logic                          wHalf_full,
  output logic                          write_enable,
  output logic [DATA_WIDTH-1:0]         data_write,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] owner, owner_nxt;
  logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
  logic [7:0]     beat_cnt, beat_cnt_nxt;
  logic [7:0]     limit, limit_nxt;

  logic [IDW-1:0] pick;
  logic           pick_vld;
  logic           owner_vld;

  // Modulo-NUM_REQ increment; explicit compare so non-power-of-two NUM_REQ
  // never produces an index past the last lane.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] idx);
    if (idx == IDW'(NUM_REQ - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  // Round-robin search starting at rr_ptr; first valid lane in wrap order wins.
  always_comb begin : rr_select
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!pick_vld && req_valid[idx]) begin
        pick     = IDW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign owner_vld  = req_valid[owner];
  assign data_write = req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
  assign grant_id   = owner;
  assign busy       = (state == BURST);

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      limit    <= 8'(MAX_BURST);
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
      limit    <= limit_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    limit_nxt    = limit;
    write_enable = 1'b0;
    req_ready    = '0;

    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt    = BURST;
          owner_nxt    = pick;
          beat_cnt_nxt = '0;
          limit_nxt    = wHalf_full ? 8'(HALF_BURST) : 8'(MAX_BURST);
        end
      end

      BURST: begin
        if (!owner_vld) begin
          // Owner dropped valid: it forfeits the rest of its burst.
          state_nxt  = IDLE;
          rr_ptr_nxt = wrap_inc(owner);
        end else if (!wfull) begin
          write_enable     = 1'b1;
          req_ready[owner] = 1'b1;
          beat_cnt_nxt     = beat_cnt + 8'd1;
          if (beat_cnt == limit - 8'd1) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = wrap_inc(owner);
          end
        end
        // wfull with owner valid: everything holds, grant kept.
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=9, MAX_BURST=8,
// HALF_BURST=2). Each lane carries {lane index, word counter}; a lane's counter
// advances only on cycles the bench itself expects that lane to be accepted.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic [3:0]  req_valid;
  logic [35:0] req_data;
  logic [3:0]  req_ready;
  logic        wfull;
  logic        wHalf_full;
  logic        write_enable;
  logic [8:0]  data_write;
  logic [1:0]  grant_id;
  logic        busy;

  int cnt [4];
  int n_chk  = 0;
  int n_pass = 0;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (9),
    .MAX_BURST  (8),
    .HALF_BURST (2)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .wfull        (wfull),
    .wHalf_full   (wHalf_full),
    .write_enable (write_enable),
    .data_write   (data_write),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  function automatic logic [8:0] lane(input int i);
    return {2'(i), 7'(cnt[i])};
  endfunction

  task automatic drive_lanes();
    for (int i = 0; i < 4; i++) begin
      req_data[i*9 +: 9] = lane(i);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic we, input logic [3:0] rdy,
                            input logic [1:0] gid, input logic bsy);
    check({tag, ".we"},    32'(write_enable), 32'(we));
    check({tag, ".ready"}, 32'(req_ready),    32'(rdy));
    check({tag, ".gid"},   32'(grant_id),     32'(gid));
    check({tag, ".busy"},  32'(busy),         32'(bsy));
    check({tag, ".data"},  32'(data_write),   32'(lane(int'(gid))));
  endtask

  // One clock cycle: check outputs mid-cycle, pass the edge, then let the
  // producers that were expected to be accepted present their next word.
  task automatic tick(input string tag, input logic we, input logic [3:0] rdy,
                      input logic [1:0] gid, input logic bsy);
    @(negedge wclk);
    check_outs(tag, we, rdy, gid, bsy);
    @(posedge wclk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (rdy[i]) cnt[i]++;
    end
    drive_lanes();
  endtask

  initial begin
    int words;
    int c;
    int prev;
    wrst_n     = 1'b0;
    req_valid  = '0;
    wfull      = 1'b0;
    wHalf_full = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    drive_lanes();

    // Reset state
    @(posedge wclk);
    #1;
    tick("reset", 1'b0, 4'b0000, 2'd0, 1'b0);
    wrst_n = 1'b1;
    tick("post_reset", 1'b0, 4'b0000, 2'd0, 1'b0);

    // Single requester on lane 2, 20 words: 8 + 8 + 4 with one idle between
    req_valid = 4'b0100;
    words = 0;
    c = 0;
    while (words < 20) begin
      if (c % 9 == 0) begin
        tick("single_idle", 1'b0, 4'b0000, (c == 0) ? 2'd0 : 2'd2, 1'b0);
      end else begin
        tick("single_beat", 1'b1, 4'b0100, 2'd2, 1'b1);
        words++;
      end
      c++;
    end
    req_valid = 4'b0000;
    tick("single_release", 1'b0, 4'b0000, 2'd2, 1'b1);
    tick("single_end", 1'b0, 4'b0000, 2'd2, 1'b0);

    // Asynchronous reset while idle clears owner
    wrst_n = 1'b0;
    #1;
    check_outs("async_reset", 1'b0, 4'b0000, 2'd0, 1'b0);
    @(posedge wclk);
    #1;
    wrst_n = 1'b1;

    // Fairness: all four valid, five grants 0,1,2,3,0 of 8 beats each
    req_valid = 4'b1111;
    prev = 0;
    for (int g = 0; g < 5; g++) begin
      tick("fair_idle", 1'b0, 4'b0000, 2'(prev), 1'b0);
      for (int b = 0; b < 8; b++) begin
        tick("fair_beat", 1'b1, 4'(1 << (g % 4)), 2'(g % 4), 1'b1);
      end
      prev = g % 4;
    end
    req_valid = 4'b0000;
    tick("fair_end", 1'b0, 4'b0000, 2'd0, 1'b0);

    // Backpressure: lane 1, 3 beats, 5 stalled cycles, 5 more beats
    req_valid = 4'b0010;
    tick("bp_idle", 1'b0, 4'b0000, 2'd0, 1'b0);
    for (int b = 0; b < 3; b++) tick("bp_beat_a", 1'b1, 4'b0010, 2'd1, 1'b1);
    wfull = 1'b1;
    for (int s = 0; s < 5; s++) tick("bp_stall", 1'b0, 4'b0000, 2'd1, 1'b1);
    wfull = 1'b0;
    for (int b = 0; b < 5; b++) tick("bp_beat_b", 1'b1, 4'b0010, 2'd1, 1'b1);
    req_valid = 4'b0000;
    tick("bp_end", 1'b0, 4'b0000, 2'd1, 1'b0);

    // Half-full throttle: grant under half-full gives 2 beats, next gives 8
    req_valid  = 4'b0001;
    wHalf_full = 1'b1;
    tick("hf_idle", 1'b0, 4'b0000, 2'd1, 1'b0);
    wHalf_full = 1'b0;
    for (int b = 0; b < 2; b++) tick("hf_short", 1'b1, 4'b0001, 2'd0, 1'b1);
    tick("hf_gap", 1'b0, 4'b0000, 2'd0, 1'b0);
    for (int b = 0; b < 8; b++) tick("hf_full", 1'b1, 4'b0001, 2'd0, 1'b1);
    req_valid = 4'b0000;
    tick("hf_end", 1'b0, 4'b0000, 2'd0, 1'b0);

    // Early release: owner 1 drops after 3 beats, lane 3 takes over
    req_valid = 4'b1010;
    tick("er_idle", 1'b0, 4'b0000, 2'd0, 1'b0);
    for (int b = 0; b < 3; b++) tick("er_beat", 1'b1, 4'b0010, 2'd1, 1'b1);
    req_valid = 4'b1000;
    tick("er_release", 1'b0, 4'b0000, 2'd1, 1'b1);
    tick("er_gap", 1'b0, 4'b0000, 2'd1, 1'b0);
    tick("er_next", 1'b1, 4'b1000, 2'd3, 1'b1);
    req_valid = 4'b0100;
    tick("er_release3", 1'b0, 4'b0000, 2'd3, 1'b1);
    tick("er_gap3", 1'b0, 4'b0000, 2'd3, 1'b0);

    // Reset during beat 4 of owner 2
    for (int b = 0; b < 3; b++) tick("rst_beat", 1'b1, 4'b0100, 2'd2, 1'b1);
    @(negedge wclk);
    check("rst_beat4.we", 32'(write_enable), 32'd1);
    #2;
    wrst_n    = 1'b0;
    req_valid = 4'b0110;
    #1;
    check_outs("rst_mid", 1'b0, 4'b0000, 2'd0, 1'b0);
    @(posedge wclk);
    #1;
    check_outs("rst_hold", 1'b0, 4'b0000, 2'd0, 1'b0);
    wrst_n = 1'b1;
    tick("rst_release", 1'b0, 4'b0000, 2'd0, 1'b0);
    tick("rst_first", 1'b1, 4'b0010, 2'd1, 1'b1);
    req_valid = 4'b0000;
    tick("rst_done", 1'b0, 4'b0000, 2'd1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side round-robin arbiter that shares the single write port of the async FIFO among `NUM_REQ` producers in the `wclk` domain. It grants one producer at a time for a bounded burst, drives `write_enable`/`data_write` straight into the FIFO write port, and throttles burst length from the FIFO's `wfull` and `wHalf_full` flags. It sits between the producer ports and the FIFO write side.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 9: FIFO word width.
- `MAX_BURST`, 8: beats per grant when FIFO is below half full, 1..255.
- `HALF_BURST`, 2: beats per grant when `wHalf_full` is sampled high at grant, 1..`MAX_BURST`.
- `IDW` (localparam), `$clog2(NUM_REQ)`: width of `grant_id`.

- `wclk`  in  1  sole clock, rising edge.
- `wrst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  bit i: requester i has a word on its lane.
- `req_data`  in  NUM_REQ*DATA_WIDTH  lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready`  out  NUM_REQ  bit i: lane i word is accepted this cycle.
- `wfull`  in  1  FIFO full flag, `wclk` domain.
- `wHalf_full`  in  1  FIFO half-full flag, `wclk` domain.
- `write_enable`  out  1  FIFO write strobe.
- `data_write`  out  DATA_WIDTH  FIFO write data.
- `grant_id`  out  IDW  current/last owner index.
- `busy`  out  1  high in BURST state.

## Operation
- FSM states: IDLE, BURST. Registers: `state`, `owner` (IDW), `rr_ptr` (IDW), `beat_cnt` (8b), `limit` (8b).
- IDLE: if `|req_valid`, select first i with `req_valid[i]` searching `rr_ptr, rr_ptr+1, … ` modulo `NUM_REQ`; next cycle: `state`=BURST, `owner`=i, `beat_cnt`=0, `limit`=`wHalf_full ? HALF_BURST : MAX_BURST`. No valid: remain IDLE.
- BURST, combinational: `write_enable` = `req_valid[owner] & ~wfull`; `data_write` = lane `owner`; `req_ready[owner]` = `write_enable`; all other `req_ready` bits 0.
- BURST, beat (write_enable=1): `beat_cnt`++; if `beat_cnt == limit-1` -> IDLE, `rr_ptr` = (`owner`+1) mod `NUM_REQ`.
- BURST, `req_valid[owner]`=0: release -> IDLE, `rr_ptr` = (`owner`+1) mod `NUM_REQ`; no beat that cycle.
- BURST, `wfull`=1 with owner valid: stall, hold all state, no beat, grant kept.
- In IDLE: `write_enable`=0, `req_ready`=0, `data_write`=lane `grant_id` (don't-care to FIFO).
- `grant_id` = `owner`; `busy` = (state==BURST).
- Producers must hold `req_valid`/lane data stable until `req_ready`; a producer dropping valid forfeits its grant.
- `rr_ptr` wrap: `NUM_REQ-1` + 1 -> 0; non-power-of-two `NUM_REQ` must not select invalid indices.

## Timing
- Reset (async, `wrst_n`=0): state=IDLE, `owner`=0, `rr_ptr`=0, `beat_cnt`=0, `limit`=`MAX_BURST`; outputs `write_enable`=0, `req_ready`=0, `busy`=0, `grant_id`=0, `data_write`=lane 0. Reset mid-burst aborts immediately; no write strobe during or on the first edge after reset release.
- Arbitration latency: valid seen in IDLE at edge N -> first beat possible in cycle N+1 (one IDLE cycle between grants).
- Throughput: 1 beat/cycle within a burst; `limit` beats then one IDLE cycle.
- `write_enable`, `req_ready`, `data_write` are combinational from registered state plus `req_valid`, `wfull`, `req_data`; no path from `wHalf_full` to outputs.
- `limit` sampled only at the IDLE->BURST transition; `wHalf_full` changing mid-burst has no effect.
- `wfull` rising mid-burst: beats cease in the same cycle; resume the cycle `wfull` falls.
- Simultaneous last beat and other valids: IDLE next cycle, search starts at `owner+1`.

## Test plan
- Single requester: `req_valid`=4'b0100 held, 20 words, FIFO empty -> grant_id=2, bursts of 8 beats separated by 1 idle cycle, 20 writes in order, `req_ready[2]` only.
- Fairness: all four valid continuously, `MAX_BURST`=8 -> grant sequence 0,1,2,3,0…, exactly 8 beats each, no lane starved.
- Backpressure: mid-burst force `wfull`=1 for 5 cycles -> `write_enable`=0, `beat_cnt` frozen, grant held; burst completes 8 total beats after release, no word lost or duplicated.
- Half-full throttle: `wHalf_full`=1 at grant -> burst length 2; drop `wHalf_full` mid-burst -> still 2; next grant uses 8.
- Early release: owner 1 drops valid after 3 beats with lane 3 valid -> IDLE one cycle, then grant_id=3.
- Reset mid-burst: `wrst_n` low during beat 4 of owner 2 -> outputs zero asynchronously; after release first grant searches from index 0.
